// File: rtl/mi_nios_touch_pkg.sv
// Shared constants for the touch pen interrupt slave: register map, bit indices, idle level.
package mi_nios_touch_pkg;

   localparam int unsigned ADDR_W = 2;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned IRQ_W  = 2;

   typedef enum logic [ADDR_W-1:0] {
      ADDR_DATA    = 2'd0,
      ADDR_RSVD    = 2'd1,
      ADDR_IRQMASK = 2'd2,
      ADDR_EDGECAP = 2'd3
   } addr_e;

   localparam int unsigned BIT_PRESS   = 0;
   localparam int unsigned BIT_RELEASE = 1;

   // Pen line level when nobody is touching the panel
   localparam logic PEN_IDLE = 1'b1;

endpackage

// File: rtl/mi_nios_touch_debounce.sv
// Two-flop synchronizer plus stable-count debouncer for the raw pen line.
// fall_pulse/rise_pulse are high in the cycle whose closing edge updates out_db.
module mi_nios_touch_debounce
   import mi_nios_touch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in_raw,
   output logic out_db,
   output logic fall_pulse,
   output logic rise_pulse
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             pen_s;
   logic [CNT_W-1:0] cnt;
   logic             differ;
   logic             settle;

   // Metastability guard on the asynchronous pen line
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {2{PEN_IDLE}};
      end else begin
         sync_q <= {sync_q[0], in_raw};
      end
   end

   assign pen_s  = sync_q[1];
   assign differ = (pen_s != out_db);
   assign settle = differ && (cnt == CNT_LAST);

   // Any return to the current level restarts the stability count
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_db <= PEN_IDLE;
         cnt    <= '0;
      end else if (settle) begin
         out_db <= pen_s;
         cnt    <= '0;
      end else if (differ) begin
         cnt    <= cnt + CNT_W'(1);
      end else begin
         cnt    <= '0;
      end
   end

   assign fall_pulse = settle & ~pen_s;
   assign rise_pulse = settle &  pen_s;

endmodule

// File: rtl/mi_nios_touch_pen_irq.sv
// Avalon-MM slave: debounced pen-down line with edge capture and maskable level irq.
// Define TOUCH_PEN_RELEASE_IRQ_EN to also capture pen release in EDGECAP/IRQMASK bit1.
module mi_nios_touch_pen_irq
   import mi_nios_touch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [DATA_W-1:0] writedata,
   output logic [DATA_W-1:0] readdata,
   input  logic              in_port,
   output logic              irq
);

`ifdef TOUCH_PEN_RELEASE_IRQ_EN
   localparam logic [IRQ_W-1:0] IRQ_IMPL = 2'b11;
`else
   localparam logic [IRQ_W-1:0] IRQ_IMPL = 2'b01;
`endif

   logic              pen_db;
   logic              fall_pulse;
   logic              rise_pulse;
   logic              wr_en;
   logic [IRQ_W-1:0]  mask;
   logic [IRQ_W-1:0]  edgecap;
   logic [IRQ_W-1:0]  edge_set;
   logic [IRQ_W-1:0]  w1c;
   logic [DATA_W-1:0] rd_mux;
   logic              unused_wdata;

   mi_nios_touch_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_raw     (in_port),
      .out_db     (pen_db),
      .fall_pulse (fall_pulse),
      .rise_pulse (rise_pulse)
   );

   assign wr_en = chipselect & ~write_n;

   always_comb begin
      edge_set              = '0;
      edge_set[BIT_PRESS]   = fall_pulse;
      edge_set[BIT_RELEASE] = rise_pulse;
      edge_set              = edge_set & IRQ_IMPL;
      w1c                   = '0;
      if (wr_en && (address == ADDR_EDGECAP)) begin
         w1c = writedata[IRQ_W-1:0] & IRQ_IMPL;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask <= '0;
      end else if (wr_en && (address == ADDR_IRQMASK)) begin
         mask <= writedata[IRQ_W-1:0] & IRQ_IMPL;
      end
   end

   // A new edge on the same clock as its W1C clear keeps the bit set
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edgecap <= '0;
      end else begin
         edgecap <= (edgecap & ~w1c) | edge_set;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (addr_e'(address))
         ADDR_DATA:    rd_mux[0]         = pen_db;
         ADDR_IRQMASK: rd_mux[IRQ_W-1:0] = mask;
         ADDR_EDGECAP: rd_mux[IRQ_W-1:0] = edgecap;
         default:      rd_mux            = '0;
      endcase
   end

   // Read data follows the address every clock; reads have no side effects
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         readdata <= rd_mux;
      end
   end

   assign irq = |(edgecap & mask);

   assign unused_wdata = ^writedata[DATA_W-1:IRQ_W];

endmodule

// File: tb/tb_mi_nios_touch_pen_irq.sv
// Self-checking bench for mi_nios_touch_pen_irq with DEBOUNCE_CYCLES=4.
// Expected read data is queued when a read is issued and popped when readdata is valid.
module tb_mi_nios_touch_pen_irq;
   import mi_nios_touch_pkg::*;

`ifdef TOUCH_PEN_RELEASE_IRQ_EN
   localparam logic [31:0] IMPL   = 32'd3;
   localparam bit          REL_EN = 1'b1;
`else
   localparam logic [31:0] IMPL   = 32'd1;
   localparam bit          REL_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        in_port;
   logic        irq;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];
   logic [31:0] rd;
   logic [31:0] exp_v;
   logic        exp_irq;

   mi_nios_touch_pen_irq #(
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      tick();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      tick();
      d = readdata;
      chipselect = 1'b0;
   endtask

   task automatic test_reset();
      logic [1:0] ra[3];
      ra = '{ADDR_DATA, ADDR_IRQMASK, ADDR_EDGECAP};
      reset_n = 1'b0; in_port = 1'b1; chipselect = 1'b0; write_n = 1'b1;
      address = '0; writedata = '0;
      repeat (3) tick();
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
      checks++;
      if (readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata: got %h expected 0", readdata); end
      reset_n = 1'b1;
      exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      for (int i = 0; i < 3; i++) begin
         bus_read(ra[i], rd);
         exp_v = exp_q.pop_front();
         checks++;
         if (rd !== exp_v) begin errors++; $display("FAIL reset_read addr%0d: got %h expected %h", ra[i], rd, exp_v); end
         checks++;
         if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq_after: got %b expected 0", irq); end
      end
   endtask

   task automatic test_regs();
      logic [1:0] ra[3];
      ra = '{ADDR_DATA, ADDR_RSVD, ADDR_IRQMASK};
      bus_write(ADDR_RSVD, 32'hFFFF_FFFF);
      bus_write(ADDR_DATA, 32'h0000_0000);
      bus_write(ADDR_IRQMASK, 32'hFFFF_FFFF);
      exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(IMPL);
      for (int i = 0; i < 3; i++) begin
         bus_read(ra[i], rd);
         exp_v = exp_q.pop_front();
         checks++;
         if (rd !== exp_v) begin errors++; $display("FAIL regs_read addr%0d: got %h expected %h", ra[i], rd, exp_v); end
      end
      bus_write(ADDR_IRQMASK, 32'd0);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL regs_irq: got %b expected 0", irq); end
   endtask

   task automatic test_press();
      bus_write(ADDR_IRQMASK, 32'd1);
      in_port = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         tick();
         exp_irq = (e == 6);
         checks++;
         if (irq !== exp_irq) begin errors++; $display("FAIL press_irq edge%0d: got %b expected %b", e, irq, exp_irq); end
      end
      exp_q.push_back(32'd1); bus_read(ADDR_EDGECAP, rd); exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin errors++; $display("FAIL press_edgecap: got %h expected %h", rd, exp_v); end
      exp_q.push_back(32'd0); bus_read(ADDR_DATA, rd); exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin errors++; $display("FAIL press_data: got %h expected %h", rd, exp_v); end
      bus_write(ADDR_EDGECAP, 32'd1);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL press_w1c_irq: got %b expected 0", irq); end
      in_port = 1'b1;
      repeat (8) tick();
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL release_irq_masked: got %b expected 0", irq); end
      exp_q.push_back(32'd1); bus_read(ADDR_DATA, rd); exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin errors++; $display("FAIL release_data: got %h expected %h", rd, exp_v); end
      exp_q.push_back(REL_EN ? 32'd2 : 32'd0); bus_read(ADDR_EDGECAP, rd); exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin errors++; $display("FAIL release_edgecap: got %h expected %h", rd, exp_v); end
      bus_write(ADDR_EDGECAP, 32'd3);
   endtask

   task automatic test_glitch();
      in_port = 1'b0;
      repeat (3) tick();
      in_port = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++;
         if (irq !== 1'b0) begin errors++; $display("FAIL glitch_irq cycle%0d: got %b expected 0", c, irq); end
      end
      exp_q.push_back(32'd1); bus_read(ADDR_DATA, rd); exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin errors++; $display("FAIL glitch_data: got %h expected %h", rd, exp_v); end
      exp_q.push_back(32'd0); bus_read(ADDR_EDGECAP, rd); exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin errors++; $display("FAIL glitch_edgecap: got %h expected %h", rd, exp_v); end
   endtask

   task automatic test_clear_race();
      in_port = 1'b0;
      repeat (5) tick();
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL race_pre_irq: got %b expected 0", irq); end
      bus_write(ADDR_EDGECAP, 32'd1);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL race_set_wins_irq: got %b expected 1", irq); end
      exp_q.push_back(32'd1); bus_read(ADDR_EDGECAP, rd); exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin errors++; $display("FAIL race_edgecap: got %h expected %h", rd, exp_v); end
      bus_write(ADDR_EDGECAP, 32'd1);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL race_clear_irq: got %b expected 0", irq); end
      exp_q.push_back(32'd0); bus_read(ADDR_EDGECAP, rd); exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin errors++; $display("FAIL race_cleared: got %h expected %h", rd, exp_v); end
      in_port = 1'b1;
      repeat (8) tick();
      bus_write(ADDR_EDGECAP, 32'd3);
   endtask

   task automatic test_mask();
      bus_write(ADDR_IRQMASK, 32'd0);
      in_port = 1'b0;
      repeat (8) tick();
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL mask_off_irq: got %b expected 0", irq); end
      exp_q.push_back(32'd1); bus_read(ADDR_EDGECAP, rd); exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin errors++; $display("FAIL mask_pending: got %h expected %h", rd, exp_v); end
      bus_write(ADDR_IRQMASK, 32'd1);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL mask_on_irq: got %b expected 1", irq); end
      bus_write(ADDR_IRQMASK, 32'd0);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL mask_drop_irq: got %b expected 0", irq); end
      bus_write(ADDR_EDGECAP, 32'd1);
      in_port = 1'b1;
      repeat (8) tick();
      bus_write(ADDR_EDGECAP, 32'd3);
   endtask

   task automatic test_reset_mid();
      in_port = 1'b0;
      repeat (3) tick();
      reset_n = 1'b0;
      repeat (2) tick();
      checks++;
      if (readdata !== 32'd0 || irq !== 1'b0) begin
         errors++; $display("FAIL midreset_state: got rd=%h irq=%b expected 0/0", readdata, irq);
      end
      reset_n = 1'b1;
      address = ADDR_IRQMASK; writedata = 32'd1; chipselect = 1'b1; write_n = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         tick();
         chipselect = 1'b0; write_n = 1'b1;
         exp_irq = (c == 6);
         checks++;
         if (irq !== exp_irq) begin errors++; $display("FAIL midreset_irq clock%0d: got %b expected %b", c, irq, exp_irq); end
      end
      exp_q.push_back(32'd0); bus_read(ADDR_DATA, rd); exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin errors++; $display("FAIL midreset_data: got %h expected %h", rd, exp_v); end
   endtask

   task automatic test_release();
      in_port = 1'b1;
      repeat (8) tick();
      bus_write(ADDR_EDGECAP, 32'd3);
      bus_write(ADDR_IRQMASK, 32'd2);
      in_port = 1'b0;
      repeat (8) tick();
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL release_press_irq: got %b expected 0", irq); end
      in_port = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         tick();
         exp_irq = REL_EN && (e == 6);
         checks++;
         if (irq !== exp_irq) begin errors++; $display("FAIL release_irq edge%0d: got %b expected %b", e, irq, exp_irq); end
      end
      exp_q.push_back(REL_EN ? 32'd3 : 32'd1); bus_read(ADDR_EDGECAP, rd); exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin errors++; $display("FAIL release_edgecap_both: got %h expected %h", rd, exp_v); end
      exp_q.push_back(REL_EN ? 32'd2 : 32'd0); bus_read(ADDR_IRQMASK, rd); exp_v = exp_q.pop_front();
      checks++;
      if (rd !== exp_v) begin errors++; $display("FAIL release_mask: got %h expected %h", rd, exp_v); end
   endtask

   initial begin
      test_reset();
      test_regs();
      test_press();
      test_glitch();
      test_clear_race();
      test_mask();
      test_reset_mid();
      test_release();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
